touch_sample_ctrlmod: RTL and testbench

//  Scheduler for the touch-panel SPI function module. Debounces pen-down on TP_IRQ and

---
 rtl/touch_sample_ctrlmod.sv | 221 ++++++++++++++++++++++
 tb/tb_touch_sample_ctrlmod.sv | 423 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/touch_sample_ctrlmod.sv
// touch_sample_ctrlmod: touch-panel sample scheduler.
// Debounces pen-down on TP_IRQ (active-low, two-flop synced), then drives
// N = 1<<SAMPLES_LOG2 read-X/read-Y call pairs to the SPI function module,
// averages each axis and reports one X/Y pair per set. Sets repeat every
// INTERVAL cycles while the pen is held.
// Optional macro TOUCH_SPREAD_FILTER_EN: track per-axis min/max and drop sets
// whose spread exceeds SPREAD_MAX on either axis.
// Call handshake: an oCall bit is the request and stays high until the
// one-cycle iDone response, which carries iData in the same cycle. A request
// rises the cycle after its state is entered, only one bit is ever high, and
// there is always at least one low cycle between two requests. iDone is only
// consumed while the matching request bit is high.
// oState exposes the FSM state for debug and checker binding.
module touch_sample_ctrlmod #(
    parameter int SAMPLES_LOG2 = 2,
    parameter int DEBOUNCE     = 50000,
    parameter int INTERVAL     = 500000,
    parameter int SPREAD_MAX   = 16
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       TP_IRQ,
    output logic [1:0] oCall,
    input  logic       iDone,
    input  logic [7:0] iData,
    output logic       oDone,
    output logic [7:0] oX,
    output logic [7:0] oY,
    output logic       oPress,
    output logic [2:0] oState
);

    localparam int AW      = 8 + SAMPLES_LOG2;
    localparam int KW      = SAMPLES_LOG2 + 1;
    localparam int CNT_MAX = (DEBOUNCE > INTERVAL) ? DEBOUNCE : INTERVAL;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] INT_LAST   = CW'(INTERVAL - 1);
    localparam logic [KW-1:0] N_SAMP     = KW'(1 << SAMPLES_LOG2);
    localparam logic [8:0]    SPREAD_LIM = 9'(SPREAD_MAX);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_DEBOUNCE = 3'd1,
        S_CALL_X   = 3'd2,
        S_CALL_Y   = 3'd3,
        S_CHECK    = 3'd4,
        S_REPORT   = 3'd5,
        S_WAIT     = 3'd6
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic            r_irq_meta;
    logic            r_irq_sync;
    logic [CW-1:0]   r_cnt;
    logic [1:0]      r_call;
    logic [AW-1:0]   r_acc_x;
    logic [AW-1:0]   r_acc_y;
    logic [KW-1:0]   r_k;
    logic            r_done;
    logic [7:0]      r_x;
    logic [7:0]      r_y;
    logic            r_press;

    logic w_irq_low;
    logic w_x_done;
    logic w_y_done;
    logic w_last_pair;
    logic w_deb_end;
    logic w_wait_end;
    logic w_accept;
    logic w_call_x;
    logic w_call_y;
    logic w_report;
    logic w_clear;
    logic w_cnt_run;
    logic w_press_set;
    logic w_press_clr;

    assign w_irq_low   = ~r_irq_sync;
    assign w_x_done    = (r_state == S_CALL_X) && r_call[1] && iDone;
    assign w_y_done    = (r_state == S_CALL_Y) && r_call[0] && iDone;
    assign w_last_pair = ((r_k + KW'(1)) == N_SAMP);
    assign w_deb_end   = (r_cnt == DEB_LAST);
    assign w_wait_end  = (r_cnt == INT_LAST);

    // Two-flop synchroniser for the asynchronous pen interrupt (idles high).
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_irq_meta <= 1'b1;
            r_irq_sync <= 1'b1;
        end else begin
            r_irq_meta <= TP_IRQ;
            r_irq_sync <= r_irq_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge CLOCK) begin
        if (RESET) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; the pen is only looked at in IDLE, DEBOUNCE and WAIT.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_irq_low) w_next = S_DEBOUNCE;
            S_DEBOUNCE: begin
                if (!w_irq_low)     w_next = S_IDLE;
                else if (w_deb_end) w_next = S_CALL_X;
            end
            S_CALL_X:   if (w_x_done) w_next = S_CALL_Y;
            S_CALL_Y:   if (w_y_done) w_next = w_last_pair ? S_CHECK : S_CALL_X;
            S_CHECK:    w_next = w_accept ? S_REPORT : S_WAIT;
            S_REPORT:   w_next = S_WAIT;
            S_WAIT:     if (w_wait_end) w_next = w_irq_low ? S_CALL_X : S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Output/control decode from the current state and its transition.
    always_comb begin
        w_call_x    = (r_state == S_CALL_X) && !w_x_done;
        w_call_y    = (r_state == S_CALL_Y) && !w_y_done;
        w_report    = (r_state == S_CHECK) && w_accept;
        w_clear     = (r_state == S_IDLE) || (r_state == S_WAIT);
        w_cnt_run   = ((r_state == S_DEBOUNCE) || (r_state == S_WAIT)) && (w_next == r_state);
        w_press_set = (r_state == S_DEBOUNCE) && (w_next == S_CALL_X);
        w_press_clr = (r_state == S_WAIT) && (w_next == S_IDLE);
    end

    // Interval/debounce counter and registered call requests.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_cnt  <= '0;
            r_call <= 2'b00;
        end else begin
            r_cnt  <= w_cnt_run ? (r_cnt + CW'(1)) : '0;
            r_call <= {w_call_x, w_call_y};
        end
    end

    // Sample accumulation; sums are wide enough that N samples never overflow.
    always_ff @(posedge CLOCK) begin
        if (RESET || w_clear) begin
            r_acc_x <= '0;
            r_acc_y <= '0;
            r_k     <= '0;
        end else begin
            if (w_x_done) r_acc_x <= r_acc_x + AW'(iData);
            if (w_y_done) begin
                r_acc_y <= r_acc_y + AW'(iData);
                r_k     <= r_k + KW'(1);
            end
        end
    end

    // Report registers: averages land together with the oDone pulse.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_done  <= 1'b0;
            r_x     <= 8'h00;
            r_y     <= 8'h00;
            r_press <= 1'b0;
        end else begin
            r_done <= w_report;
            if (w_report) begin
                r_x <= r_acc_x[AW-1:SAMPLES_LOG2];
                r_y <= r_acc_y[AW-1:SAMPLES_LOG2];
            end
            if (w_press_set)      r_press <= 1'b1;
            else if (w_press_clr) r_press <= 1'b0;
        end
    end

`ifdef TOUCH_SPREAD_FILTER_EN
    logic [7:0] r_min_x;
    logic [7:0] r_max_x;
    logic [7:0] r_min_y;
    logic [7:0] r_max_y;
    logic [7:0] w_spread_x;
    logic [7:0] w_spread_y;

    // Per-axis min/max of the current set; first pair of a set seeds both.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_min_x <= 8'h00;
            r_max_x <= 8'h00;
            r_min_y <= 8'h00;
            r_max_y <= 8'h00;
        end else begin
            if (w_x_done) begin
                if ((r_k == '0) || (iData < r_min_x)) r_min_x <= iData;
                if ((r_k == '0) || (iData > r_max_x)) r_max_x <= iData;
            end
            if (w_y_done) begin
                if ((r_k == '0) || (iData < r_min_y)) r_min_y <= iData;
                if ((r_k == '0) || (iData > r_max_y)) r_max_y <= iData;
            end
        end
    end

    assign w_spread_x = r_max_x - r_min_x;
    assign w_spread_y = r_max_y - r_min_y;
    assign w_accept   = ({1'b0, w_spread_x} <= SPREAD_LIM) && ({1'b0, w_spread_y} <= SPREAD_LIM);
`else
    logic w_unused_spread;
    assign w_unused_spread = ^SPREAD_LIM;
    assign w_accept        = 1'b1;
`endif

    assign oCall  = r_call;
    assign oDone  = r_done;
    assign oX     = r_x;
    assign oY     = r_y;
    assign oPress = r_press;
    assign oState = 3'(r_state);

endmodule

// File: tb/tb_touch_sample_ctrlmod.sv
// Bench for touch_sample_ctrlmod: SPI responder model, averaging reference
// model with an expected queue, and one task per scenario.
module tb_touch_sample_ctrlmod;

    localparam int DEB     = 8;
    localparam int INTV    = 64;
    localparam int SL      = 2;
    localparam int NS      = 1 << SL;
    localparam int SPR     = 16;
    localparam int SPI_LAT = 5;

    localparam int W_DONE      = 0;
    localparam int W_SETS      = 1;
    localparam int W_XRISE     = 2;
    localparam int W_PRESS_LOW = 3;

    logic       CLOCK;
    logic       RESET;
    logic       TP_IRQ;
    logic [1:0] oCall;
    logic       iDone;
    logic [7:0] iData;
    logic       oDone;
    logic [7:0] oX;
    logic [7:0] oY;
    logic       oPress;
    logic [2:0] oState;

    logic       model_done;
    logic       spur_done;
    logic [7:0] model_data;
    logic [7:0] spur_data;

    int vecs;
    int miss;
    int cyc;
    int wcnt;
    int done_cnt;
    int last_done;
    int x_rise_cnt;
    int last_x_rise;
    int call_rise_cnt;
    int last_ydone;
    int sets_done;

    logic [15:0] exp_q[$];
    logic [7:0]  x_q[$];
    logic [7:0]  y_q[$];
    int          sx[$];
    int          sy[$];
    logic [1:0]  call_log[$];
    logic [1:0]  prev_call;
    logic [7:0]  mdl_last_x;

    assign iDone = model_done | spur_done;
    assign iData = spur_done ? spur_data : model_data;

    touch_sample_ctrlmod #(
        .SAMPLES_LOG2(SL),
        .DEBOUNCE    (DEB),
        .INTERVAL    (INTV),
        .SPREAD_MAX  (SPR)
    ) dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .TP_IRQ(TP_IRQ),
        .oCall (oCall),
        .iDone (iDone),
        .iData (iData),
        .oDone (oDone),
        .oX    (oX),
        .oY    (oY),
        .oPress(oPress),
        .oState(oState)
    );

    // Clock and reset defaults
    initial begin
        CLOCK      = 1'b0;
        RESET      = 1'b1;
        TP_IRQ     = 1'b1;
        model_done = 1'b0;
        model_data = 8'h00;
        spur_done  = 1'b0;
        spur_data  = 8'h00;
        prev_call  = 2'b00;
        mdl_last_x = 8'h00;
    end
    always #5 CLOCK = ~CLOCK;

    // Monitor, SPI responder and reference model, all on the falling edge.
    always @(negedge CLOCK) begin : monitor
        int sumx, sumy, mnx, mxx, mny, mxy;
        bit acc;
        logic [7:0]  d;
        logic [15:0] e;
        cyc++;
        model_done = 1'b0;
        if (RESET) begin
            wcnt      = 0;
            prev_call = oCall;
        end else begin
            vecs++;
            if (oCall == 2'b11 || (prev_call != 2'b00 && oCall != 2'b00 && oCall != prev_call)) begin
                miss++;
                $display("FAIL handshake cyc=%0d: oCall=%b after %b, required one bit with a low gap", cyc, oCall, prev_call);
            end
            if (oCall != prev_call) call_log.push_back(oCall);
            if (prev_call == 2'b00 && oCall != 2'b00) call_rise_cnt++;
            if (prev_call == 2'b00 && oCall == 2'b10) begin
                x_rise_cnt++;
                last_x_rise = cyc;
            end
            prev_call = oCall;
            if (oCall != 2'b00) begin
                wcnt++;
                if (wcnt == SPI_LAT) begin
                    model_done = 1'b1;
                    if (oCall[1]) begin
                        if (x_q.size() != 0) d = x_q.pop_front();
                        else d = 8'($urandom_range(0, 255));
                        sx.push_back(int'(d));
                    end else begin
                        if (y_q.size() != 0) d = y_q.pop_front();
                        else d = 8'($urandom_range(0, 255));
                        sy.push_back(int'(d));
                    end
                    model_data = d;
                    if (sy.size() == NS) begin
                        sumx = 0; sumy = 0; mnx = 255; mxx = 0; mny = 255; mxy = 0;
                        foreach (sx[i]) begin
                            sumx += sx[i];
                            if (sx[i] < mnx) mnx = sx[i];
                            if (sx[i] > mxx) mxx = sx[i];
                        end
                        foreach (sy[i]) begin
                            sumy += sy[i];
                            if (sy[i] < mny) mny = sy[i];
                            if (sy[i] > mxy) mxy = sy[i];
                        end
`ifdef TOUCH_SPREAD_FILTER_EN
                        acc = ((mxx - mnx) <= SPR) && ((mxy - mny) <= SPR);
`else
                        acc = 1'b1;
`endif
                        if (acc) begin
                            exp_q.push_back({8'(sumx / NS), 8'(sumy / NS)});
                            mdl_last_x = 8'(sumx / NS);
                        end
                        sets_done++;
                        last_ydone = cyc;
                        sx.delete();
                        sy.delete();
                    end
                end
            end else begin
                wcnt = 0;
            end
            if (oDone) begin
                vecs++;
                done_cnt++;
                last_done = cyc;
                if (exp_q.size() == 0) begin
                    miss++;
                    $display("FAIL report_unexpected cyc=%0d: oDone with oX=%h oY=%h, required no report", cyc, oX, oY);
                end else begin
                    e = exp_q.pop_front();
                    if ({oX, oY} !== e) begin
                        miss++;
                        $display("FAIL report_avg cyc=%0d: oX=%h oY=%h, required oX=%h oY=%h", cyc, oX, oY, e[15:8], e[7:0]);
                    end
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge CLOCK);
            #1;
        end
    endtask

    function automatic int probe(input int which);
        case (which)
            W_DONE:  return done_cnt;
            W_SETS:  return sets_done;
            W_XRISE: return x_rise_cnt;
            default: return (oPress === 1'b0) ? 1 : 0;
        endcase
    endfunction

    task automatic wait_for(input int which, input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i <= budget && !ok; i++) begin
            if (probe(which) >= target) ok = 1'b1;
            else tick(1);
        end
    endtask

    task automatic queue_tight_set();
        int bx, by;
        bx = $urandom_range(0, 239);
        by = $urandom_range(0, 239);
        for (int i = 0; i < NS; i++) begin
            x_q.push_back(8'(bx + $urandom_range(0, SPR)));
            y_q.push_back(8'(by + $urandom_range(0, SPR)));
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        tick(2);
        vecs++; if (oCall !== 2'b00) begin miss++; $display("FAIL reset_call: oCall=%b, required 00", oCall); end
        vecs++; if (oDone !== 1'b0)  begin miss++; $display("FAIL reset_done: oDone=%b, required 0", oDone); end
        vecs++; if (oX !== 8'h00)    begin miss++; $display("FAIL reset_x: oX=%h, required 00", oX); end
        vecs++; if (oY !== 8'h00)    begin miss++; $display("FAIL reset_y: oY=%h, required 00", oY); end
        vecs++; if (oPress !== 1'b0) begin miss++; $display("FAIL reset_press: oPress=%b, required 0", oPress); end
        RESET = 1'b0;
        tick(3);
    endtask

    task automatic test_glitch();
        int r0, bad;
        r0  = call_rise_cnt;
        bad = 0;
        TP_IRQ = 1'b0;
        tick(5);
        TP_IRQ = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (oPress !== 1'b0 || oCall !== 2'b00) bad++;
        end
        vecs++; if (call_rise_cnt - r0 !== 0) begin miss++; $display("FAIL glitch_calls: %0d call rises, required 0", call_rise_cnt - r0); end
        vecs++; if (bad !== 0) begin miss++; $display("FAIL glitch_press: %0d cycles with oPress/oCall active, required 0", bad); end
    endtask

    task automatic test_pen_held();
        int d0, t1, t2, r0, r1;
        bit ok;
        logic [1:0] ec;
        d0 = done_cnt;
        call_log.delete();
        for (int i = 0; i < NS; i++) begin
            x_q.push_back(8'(8'h40 + i));
            y_q.push_back(8'h80);
        end
        TP_IRQ = 1'b0;
        wait_for(W_DONE, d0 + 1, 400, ok);
        vecs++; if (!ok) begin miss++; $display("FAIL held_first_set: timeout, required one oDone"); end
        vecs++; if (call_log.size() !== 4 * NS) begin miss++; $display("FAIL held_call_seq_len: %0d changes, required %0d", call_log.size(), 4 * NS); end
        for (int i = 0; i < 4 * NS && i < call_log.size(); i++) begin
            ec = (i % 4 == 0) ? 2'b10 : ((i % 4 == 2) ? 2'b01 : 2'b00);
            vecs++;
            if (call_log[i] !== ec) begin miss++; $display("FAIL held_call_seq[%0d]: oCall=%b, required %b", i, call_log[i], ec); end
        end
        vecs++; if (oX !== 8'h41) begin miss++; $display("FAIL held_x: oX=%h, required 41", oX); end
        vecs++; if (oY !== 8'h80) begin miss++; $display("FAIL held_y: oY=%h, required 80", oY); end
        vecs++; if (oPress !== 1'b1) begin miss++; $display("FAIL held_press: oPress=%b, required 1", oPress); end
        vecs++; if (last_done - last_ydone !== 2) begin miss++; $display("FAIL held_latency: %0d cycles, required 2", last_done - last_ydone); end
        queue_tight_set();
        t1 = last_done;
        r0 = x_rise_cnt;
        wait_for(W_XRISE, r0 + 1, 200, ok);
        vecs++; if (!ok) begin miss++; $display("FAIL held_second_start: timeout, required a new X call"); end
        vecs++; if (last_x_rise - t1 !== INTV + 2) begin miss++; $display("FAIL held_interval: call %0d cycles after oDone, required %0d", last_x_rise - t1, INTV + 2); end
        wait_for(W_DONE, d0 + 2, 400, ok);
        vecs++; if (!ok) begin miss++; $display("FAIL held_second_set: timeout, required second oDone"); end
        t2 = last_done;
        TP_IRQ = 1'b1;
        while (cyc < t2 + INTV) tick(1);
        vecs++; if (oPress !== 1'b1) begin miss++; $display("FAIL release_press_hold: oPress=%b, required 1", oPress); end
        tick(1);
        vecs++; if (oPress !== 1'b0) begin miss++; $display("FAIL release_press_drop: oPress=%b, required 0", oPress); end
        r1 = call_rise_cnt;
        tick(150);
        vecs++; if (call_rise_cnt - r1 !== 0) begin miss++; $display("FAIL release_no_third: %0d call rises, required 0", call_rise_cnt - r1); end
        vecs++; if (done_cnt - d0 !== 2) begin miss++; $display("FAIL release_done_count: %0d reports, required 2", done_cnt - d0); end
    endtask

    task automatic test_spread();
        int d0, s0, by, edone;
        bit ok;
        logic [7:0] ex;
        d0 = done_cnt;
        s0 = sets_done;
        x_q.push_back(8'h10); x_q.push_back(8'h10); x_q.push_back(8'h10); x_q.push_back(8'h40);
        by = $urandom_range(0, 240);
        for (int i = 0; i < NS; i++) y_q.push_back(8'(by + $urandom_range(0, 8)));
        TP_IRQ = 1'b0;
        wait_for(W_SETS, s0 + 1, 400, ok);
        vecs++; if (!ok) begin miss++; $display("FAIL spread_set: timeout, required a completed set"); end
        TP_IRQ = 1'b1;
        tick(5);
`ifdef TOUCH_SPREAD_FILTER_EN
        edone = 0;
`else
        edone = 1;
`endif
        ex = mdl_last_x;
`ifndef TOUCH_SPREAD_FILTER_EN
        ex = 8'h1C;
`endif
        vecs++; if (done_cnt - d0 !== edone) begin miss++; $display("FAIL spread_done: %0d reports, required %0d", done_cnt - d0, edone); end
        vecs++; if (oX !== ex) begin miss++; $display("FAIL spread_x: oX=%h, required %h", oX, ex); end
        wait_for(W_PRESS_LOW, 1, 200, ok);
        vecs++; if (!ok) begin miss++; $display("FAIL spread_release: oPress stuck, required 0"); end
    endtask

    task automatic test_spurious();
        int d0, r0, t1, xr;
        bit ok;
        d0 = done_cnt;
        r0 = call_rise_cnt;
        for (int i = 0; i < 6; i++) begin
            spur_data = 8'($urandom_range(0, 255));
            spur_done = 1'b1;
            tick(1);
            spur_done = 1'b0;
            tick(3);
        end
        vecs++; if (call_rise_cnt - r0 !== 0) begin miss++; $display("FAIL spur_idle_calls: %0d call rises, required 0", call_rise_cnt - r0); end
        vecs++; if (oPress !== 1'b0) begin miss++; $display("FAIL spur_idle_press: oPress=%b, required 0", oPress); end
        vecs++; if (done_cnt - d0 !== 0) begin miss++; $display("FAIL spur_idle_done: %0d reports, required 0", done_cnt - d0); end
        queue_tight_set();
        TP_IRQ = 1'b0;
        wait_for(W_DONE, d0 + 1, 400, ok);
        vecs++; if (!ok) begin miss++; $display("FAIL spur_first_set: timeout, required oDone"); end
        t1 = last_done;
        xr = x_rise_cnt;
        queue_tight_set();
        tick(5);
        for (int i = 0; i < 5; i++) begin
            spur_data = 8'($urandom_range(0, 255));
            spur_done = 1'b1;
            tick(1);
            spur_done = 1'b0;
            tick(7);
        end
        wait_for(W_XRISE, xr + 1, 200, ok);
        vecs++; if (!ok) begin miss++; $display("FAIL spur_wait_restart: timeout, required a new X call"); end
        vecs++; if (last_x_rise - t1 !== INTV + 2) begin miss++; $display("FAIL spur_wait_interval: call %0d cycles after oDone, required %0d", last_x_rise - t1, INTV + 2); end
        wait_for(W_DONE, d0 + 2, 400, ok);
        vecs++; if (!ok) begin miss++; $display("FAIL spur_second_set: timeout, required oDone"); end
        TP_IRQ = 1'b1;
        wait_for(W_PRESS_LOW, 1, 200, ok);
        vecs++; if (!ok) begin miss++; $display("FAIL spur_release: oPress stuck, required 0"); end
    endtask

    task automatic test_random();
        int s0;
        bit ok;
        for (int n = 0; n < 3; n++) begin
            s0 = sets_done;
            TP_IRQ = 1'b0;
            wait_for(W_SETS, s0 + 2, 800, ok);
            vecs++; if (!ok) begin miss++; $display("FAIL random_sets[%0d]: timeout, required 2 sets", n); end
            TP_IRQ = 1'b1;
            wait_for(W_PRESS_LOW, 1, 300, ok);
            vecs++; if (!ok) begin miss++; $display("FAIL random_release[%0d]: oPress stuck, required 0", n); end
            tick(3);
            vecs++; if (exp_q.size() !== 0) begin miss++; $display("FAIL random_pending[%0d]: %0d reports missing, required 0", n, exp_q.size()); end
            tick($urandom_range(1, 10));
        end
    endtask

    task automatic test_reset_mid();
        int d0, xr, r0, bad;
        bit ok;
        d0 = done_cnt;
        TP_IRQ = 1'b0;
        wait_for(W_DONE, d0 + 1, 400, ok);
        vecs++; if (!ok) begin miss++; $display("FAIL rst_mid_first_set: timeout, required oDone"); end
        xr = x_rise_cnt;
        wait_for(W_XRISE, xr + 1, 200, ok);
        vecs++; if (!ok) begin miss++; $display("FAIL rst_mid_call: timeout, required an open call"); end
        tick(2);
        RESET = 1'b1;
        tick(1);
        vecs++; if (oCall !== 2'b00) begin miss++; $display("FAIL rst_mid_call_drop: oCall=%b, required 00", oCall); end
        vecs++; if (oDone !== 1'b0)  begin miss++; $display("FAIL rst_mid_done: oDone=%b, required 0", oDone); end
        vecs++; if (oX !== 8'h00)    begin miss++; $display("FAIL rst_mid_x: oX=%h, required 00", oX); end
        vecs++; if (oY !== 8'h00)    begin miss++; $display("FAIL rst_mid_y: oY=%h, required 00", oY); end
        vecs++; if (oPress !== 1'b0) begin miss++; $display("FAIL rst_mid_press: oPress=%b, required 0", oPress); end
        tick(1);
        TP_IRQ = 1'b1;
        RESET  = 1'b0;
        sx.delete(); sy.delete(); x_q.delete(); y_q.delete();
        vecs++; if (exp_q.size() !== 0) begin miss++; $display("FAIL rst_mid_pending: %0d reports missing, required 0", exp_q.size()); end
        exp_q.delete();
        r0  = call_rise_cnt;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick(1);
            if (oPress !== 1'b0) bad++;
        end
        vecs++; if (call_rise_cnt - r0 !== 0) begin miss++; $display("FAIL rst_mid_quiet: %0d call rises, required 0", call_rise_cnt - r0); end
        vecs++; if (bad !== 0) begin miss++; $display("FAIL rst_mid_press_after: %0d cycles pressed, required 0", bad); end
    endtask

    // Scenario sequence and final report
    initial begin
        test_reset();
        test_glitch();
        test_pen_held();
        test_spread();
        test_spurious();
        test_random();
        test_reset_mid();
        tick(5);
        vecs++; if (exp_q.size() !== 0) begin miss++; $display("FAIL final_pending: %0d reports missing, required 0", exp_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

    // Watchdog for a run that stops making progress
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
